ledscan: RTL

Parametrised multiplexed 7-segment display driver: latches a hex value from one of `NSRC` requesting sources and time-multiplexes it across `DIGITS` common-select digits at a programmable scan rate. It sits at the core's output boundary, between the register/IO write-enables and the board's segment/digit pins. Beyond the fixed 4-digit, 8-source display driver it adds a scan prescaler, per-digit decimal points, a hold input, an update strobe and optional leading-zero blanking.

---
 rtl/ledscan_if.sv | 23 ++
 rtl/ledscan.sv | 112 +++++++++++
 2 files changed

// File: rtl/ledscan_if.sv
// Display-driver boundary bundle: source load requests and data in, segment/digit pins and update strobe out.
interface ledscan_if #(
  parameter int unsigned NSRC   = 8,
  parameter int unsigned DIGITS = 4
);
  logic [NSRC-1:0]                  out_en;
  logic [NSRC-1:0][4*DIGITS-1:0]    out_dat;
  logic [DIGITS-1:0]                dp_in;
  logic                             hold;
  logic [7:0]                       seg_out;
  logic [DIGITS-1:0]                digit_out;
  logic                             upd;

  modport master (
    output out_en, out_dat, dp_in, hold,
    input  seg_out, digit_out, upd
  );

  modport slave (
    input  out_en, out_dat, dp_in, hold,
    output seg_out, digit_out, upd
  );
endinterface

// File: rtl/ledscan.sv
// Multiplexed 7-segment driver: latches a hex value from the lowest requesting source and scans it across DIGITS digits.
// Optional leading-zero blanking is enabled by defining LEDSCAN_LZB_EN.
module ledscan #(
  parameter int unsigned NSRC   = 8,
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 1024
) (
  input  logic     clk,
  input  logic     reset,
  ledscan_if.slave bus
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

  logic [DIGITS-1:0][3:0] dat_q, dat_d;
  logic                   upd_q, upd_d;
  logic [PW-1:0]          pcnt_q, pcnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [7:0]             seg_q, seg_d;
  logic [DIGITS-1:0]      digit_q, digit_d;
  logic [DIGITS-1:0]      blank;
  logic                   zero_above;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Lowest-numbered requesting source wins; upd_d doubles as the "already found" flag.
  always_comb begin
    dat_d = dat_q;
    upd_d = 1'b0;
    if (!bus.hold) begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (bus.out_en[i] && !upd_d) begin
          dat_d = bus.out_dat[i];
          upd_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pcnt_d = pcnt_q + 1'b1;
    idx_d  = idx_q;
    if (pcnt_q == PMAX) begin
      pcnt_d = '0;
      idx_d  = (idx_q == IMAX) ? '0 : idx_q + 1'b1;
    end
  end

  // Walk from the top nibble down; a digit blanks while everything at or above it is zero.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
`ifdef LEDSCAN_LZB_EN
    for (int unsigned k = DIGITS; k > 1; k--) begin
      zero_above   = zero_above && (dat_q[k-1] == 4'h0);
      blank[k-1]   = zero_above;
    end
`endif
  end

  always_comb begin
    digit_d = DIGITS'(1) << idx_q;
    seg_d   = {bus.dp_in[idx_q], blank[idx_q] ? 7'h00 : hex7(dat_q[idx_q])};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dat_q   <= '0;
      upd_q   <= 1'b0;
      pcnt_q  <= '0;
      idx_q   <= '0;
      seg_q   <= '0;
      digit_q <= '0;
    end else begin
      dat_q   <= dat_d;
      upd_q   <= upd_d;
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      digit_q <= digit_d;
    end
  end

  assign bus.seg_out   = seg_q;
  assign bus.digit_out = digit_q;
  assign bus.upd       = upd_q;

endmodule
